// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the bus arbiter slice:
//   - SelectModeBus encodings returned to the masters (NONE/READ/WRITE)
//   - FSM state and grant encodings
//   - fixed response data words (decode error, timeout)
//   - slave index field of the address and small helper functions
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        SEL_NONE  = 2'b00,
        SEL_READ  = 2'b01,
        SEL_WRITE = 2'b10
    } select_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_WAIT = 2'b10,
        ST_RESP = 2'b11
    } bus_state_e;

    typedef enum logic {
        GRANT_M0 = 1'b0,
        GRANT_M1 = 1'b1
    } grant_e;

    localparam logic [31:0] BUS_ERR_DATA     = 32'h0000_0000;
    localparam logic [31:0] BUS_TIMEOUT_DATA = 32'hDEAD_BEEF;
    localparam int          SLAVE_IDX_HI     = 31;
    localparam int          SLAVE_IDX_LO     = 28;

    // Slave index field of a bus address.
    function automatic logic [3:0] slave_idx(input logic [31:0] addr);
        return addr[SLAVE_IDX_HI:SLAVE_IDX_LO];
    endfunction

    // SelectMode reported back to a master for a completed access.
    function automatic logic [1:0] select_mode(input logic rw);
        return rw ? SEL_WRITE : SEL_READ;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Bundles both master ports (M0 = core, M1 = debug/DMA), the core stall flag
// and the slave-side bus.
//   modport slave  : the arbiter's view (it serves the masters, drives slaves)
//   modport master : the environment's view (masters + slaves around it)
// Signal names keep the arbiter-relative _in/_out suffixes on both modports.
// -----------------------------------------------------------------------------
interface bus_arbiter_if #(
    parameter int NUM_SLAVES = 4
);
    logic                  m0_req_in;
    logic [31:0]           m0_addr_in;
    logic [31:0]           m0_data_in;
    logic                  m0_rw_in;
    logic [1:0]            m0_select_as_out;
    logic [31:0]           m0_data_out;

    logic                  m1_req_in;
    logic [31:0]           m1_addr_in;
    logic [31:0]           m1_data_in;
    logic                  m1_rw_in;
    logic [1:0]            m1_select_as_out;
    logic [31:0]           m1_data_out;

    logic                  hold_flag_out;

    logic [NUM_SLAVES-1:0] s_sel_out;
    logic [31:0]           s_addr_out;
    logic [31:0]           s_data_out;
    logic                  s_rw_out;
    logic [31:0]           s_data_in;
    logic                  s_ready_in;

    modport slave (
        input  m0_req_in, m0_addr_in, m0_data_in, m0_rw_in,
        output m0_select_as_out, m0_data_out,
        input  m1_req_in, m1_addr_in, m1_data_in, m1_rw_in,
        output m1_select_as_out, m1_data_out,
        output hold_flag_out,
        output s_sel_out, s_addr_out, s_data_out, s_rw_out,
        input  s_data_in, s_ready_in
    );

    modport master (
        output m0_req_in, m0_addr_in, m0_data_in, m0_rw_in,
        input  m0_select_as_out, m0_data_out,
        output m1_req_in, m1_addr_in, m1_data_in, m1_rw_in,
        input  m1_select_as_out, m1_data_out,
        input  hold_flag_out,
        input  s_sel_out, s_addr_out, s_data_out, s_rw_out,
        output s_data_in, s_ready_in
    );
endinterface

// File: rtl/bus_arbiter_decoder.sv
// -----------------------------------------------------------------------------
// bus_addr_decoder
// Combinational slave decode of the 4-bit slave index field.
//   slave_idx_in   in  4           address bits [31:28]
//   sel_out        out NUM_SLAVES  one-hot slave select (all zero on error)
//   decode_err_out out 1           index does not map to an existing slave
// NUM_SLAVES must not exceed 16 (the index field is 4 bits wide).
// -----------------------------------------------------------------------------
module bus_addr_decoder #(
    parameter int NUM_SLAVES = 4
) (
    input  logic [3:0]            slave_idx_in,
    output logic [NUM_SLAVES-1:0] sel_out,
    output logic                  decode_err_out
);

    // One-hot decode; an index with no matching slave leaves sel all zero.
    always_comb begin
        sel_out = {NUM_SLAVES{1'b0}};
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slave_idx_in == 4'(i)) begin
                sel_out[i] = 1'b1;
            end else begin
                sel_out[i] = 1'b0;
            end
        end
        decode_err_out = ~(|sel_out);
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Bus-side responder for the core's data port. Arbitrates the core (M0) over
// a second master (M1, fixed priority), decodes the address to one of
// NUM_SLAVES slaves, runs the access IDLE->ADDR->WAIT->RESP and returns
// select_as/data to the granted master for one RESP cycle. hold_flag_out
// stalls the core while its own request is outstanding.
// Ports:
//   clk  in  clock
//   rst  in  asynchronous, active-high reset
//   bus  bus_arbiter_if.slave  master ports, hold flag, slave bus
// Configuration:
//   BUS_TIMEOUT_EN  when defined, a WAIT lasting TIMEOUT cycles without
//                   s_ready_in completes with 32'hDEAD_BEEF; otherwise WAIT
//                   lasts until the slave is ready.
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NUM_SLAVES = 4
`ifdef BUS_TIMEOUT_EN
    , parameter int TIMEOUT = 16
`endif
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);

`ifdef BUS_TIMEOUT_EN
    // 5-bit counter: TIMEOUT must be in 1..32.
    localparam logic [4:0] TIMEOUT_LAST = 5'(TIMEOUT - 1);
    logic [4:0]            wait_cnt_r;
`endif

    bus_state_e            state_r;
    grant_e                grant_r;
    logic                  err_r;
    logic [NUM_SLAVES-1:0] s_sel_r;
    logic [31:0]           s_addr_r;
    logic [31:0]           s_data_r;
    logic                  s_rw_r;
    logic [1:0]            m0_sel_as_r;
    logic [31:0]           m0_data_r;
    logic [1:0]            m1_sel_as_r;
    logic [31:0]           m1_data_r;

    grant_e                req_grant_s;
    logic [31:0]           req_addr_s;
    logic [31:0]           req_wdata_s;
    logic                  req_rw_s;
    logic [NUM_SLAVES-1:0] dec_sel_s;
    logic                  dec_err_s;
    logic                  resp_go_s;
    logic [31:0]           resp_data_s;

    // Fixed-priority request mux: M0 wins whenever it is requesting.
    always_comb begin
        req_grant_s = GRANT_M0;
        req_addr_s  = bus.m0_addr_in;
        req_wdata_s = bus.m0_data_in;
        req_rw_s    = bus.m0_rw_in;
        if (bus.m0_req_in) begin
            req_grant_s = GRANT_M0;
            req_addr_s  = bus.m0_addr_in;
            req_wdata_s = bus.m0_data_in;
            req_rw_s    = bus.m0_rw_in;
        end else begin
            req_grant_s = GRANT_M1;
            req_addr_s  = bus.m1_addr_in;
            req_wdata_s = bus.m1_data_in;
            req_rw_s    = bus.m1_rw_in;
        end
    end

    bus_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_decoder (
        .slave_idx_in   (slave_idx(req_addr_s)),
        .sel_out        (dec_sel_s),
        .decode_err_out (dec_err_s)
    );

    // Completion condition and response word; s_ready_in only counts in WAIT.
    always_comb begin
        resp_go_s   = 1'b0;
        resp_data_s = BUS_ERR_DATA;
        case (state_r)
            ST_ADDR: begin
                if (err_r) begin
                    resp_go_s   = 1'b1;
                    resp_data_s = BUS_ERR_DATA;
                end else begin
                    resp_go_s   = 1'b0;
                    resp_data_s = BUS_ERR_DATA;
                end
            end
            ST_WAIT: begin
                if (bus.s_ready_in) begin
                    resp_go_s   = 1'b1;
                    // Writes return zero; the slave's data bus is not meaningful.
                    resp_data_s = s_rw_r ? 32'h0000_0000 : bus.s_data_in;
                end
`ifdef BUS_TIMEOUT_EN
                else if (wait_cnt_r == TIMEOUT_LAST) begin
                    resp_go_s   = 1'b1;
                    resp_data_s = BUS_TIMEOUT_DATA;
                end
`endif
                else begin
                    resp_go_s   = 1'b0;
                    resp_data_s = BUS_ERR_DATA;
                end
            end
            default: begin
                resp_go_s   = 1'b0;
                resp_data_s = BUS_ERR_DATA;
            end
        endcase
    end

    // Transaction FSM with all bus outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            grant_r     <= GRANT_M0;
            err_r       <= 1'b0;
            s_sel_r     <= {NUM_SLAVES{1'b0}};
            s_addr_r    <= 32'h0000_0000;
            s_data_r    <= 32'h0000_0000;
            s_rw_r      <= 1'b0;
            m0_sel_as_r <= SEL_NONE;
            m0_data_r   <= 32'h0000_0000;
            m1_sel_as_r <= SEL_NONE;
            m1_data_r   <= 32'h0000_0000;
`ifdef BUS_TIMEOUT_EN
            wait_cnt_r  <= 5'd0;
`endif
        end else if (resp_go_s) begin
            // Enter RESP: release the slave bus, present the result.
            state_r  <= ST_RESP;
            s_sel_r  <= {NUM_SLAVES{1'b0}};
            s_addr_r <= 32'h0000_0000;
            s_data_r <= 32'h0000_0000;
            s_rw_r   <= 1'b0;
            if (grant_r == GRANT_M0) begin
                m0_sel_as_r <= select_mode(s_rw_r);
                m0_data_r   <= resp_data_s;
            end else begin
                m1_sel_as_r <= select_mode(s_rw_r);
                m1_data_r   <= resp_data_s;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.m0_req_in || bus.m1_req_in) begin
                        state_r  <= ST_ADDR;
                        grant_r  <= req_grant_s;
                        err_r    <= dec_err_s;
                        s_sel_r  <= dec_sel_s;
                        s_addr_r <= req_addr_s;
                        s_data_r <= req_wdata_s;
                        s_rw_r   <= req_rw_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    state_r    <= ST_WAIT;
`ifdef BUS_TIMEOUT_EN
                    wait_cnt_r <= 5'd0;
`endif
                end
                ST_WAIT: begin
                    state_r    <= ST_WAIT;
`ifdef BUS_TIMEOUT_EN
                    wait_cnt_r <= wait_cnt_r + 5'd1;
`endif
                end
                ST_RESP: begin
                    state_r     <= ST_IDLE;
                    m0_sel_as_r <= SEL_NONE;
                    m0_data_r   <= 32'h0000_0000;
                    m1_sel_as_r <= SEL_NONE;
                    m1_data_r   <= 32'h0000_0000;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.s_sel_out        = s_sel_r;
    assign bus.s_addr_out       = s_addr_r;
    assign bus.s_data_out       = s_data_r;
    assign bus.s_rw_out         = s_rw_r;
    assign bus.m0_select_as_out = m0_sel_as_r;
    assign bus.m0_data_out      = m0_data_r;
    assign bus.m1_select_as_out = m1_sel_as_r;
    assign bus.m1_data_out      = m1_data_r;

    // Combinational on the request so the core stalls in the cycle it asks;
    // released only in the RESP cycle that serves M0.
    assign bus.hold_flag_out = bus.m0_req_in &
                               ~((state_r == ST_RESP) && (grant_r == GRANT_M0));

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter. Stimulus drives one cycle at a time and
// pushes each expected response (master, select_as, data, cycle) into a
// scoreboard queue; a monitor pops and compares whenever a master's
// select_as is non-NONE. hold_flag_out and s_sel_out are checked per cycle.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

    typedef struct {
        int          master;
        logic [1:0]  sel_as;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   t0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   mon_m;

    bus_arbiter_if #(.NUM_SLAVES(4)) bus_if ();

    bus_arbiter #(.NUM_SLAVES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_resp(input int m, input logic [1:0] s, input logic [31:0] d, input int c);
        exp_t e;
        e.master = m;
        e.sel_as = s;
        e.data   = d;
        e.cyc    = c;
        sb_q.push_back(e);
    endfunction

    // Response monitor.
    always @(negedge clk) begin
        if (!rst && (bus_if.m0_select_as_out != 2'b00 || bus_if.m1_select_as_out != 2'b00)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: m0_sel_as=%b m1_sel_as=%b, expected no response (cycle %0d)",
                         bus_if.m0_select_as_out, bus_if.m1_select_as_out, cyc);
            end else begin
                mon_e = sb_q.pop_front();
                mon_m = (bus_if.m0_select_as_out != 2'b00) ? 0 : 1;
                chk("resp_master", 32'(mon_m), 32'(mon_e.master));
                chk("resp_cycle", 32'(cyc), 32'(mon_e.cyc));
                if (mon_e.master == 0) begin
                    chk("resp_m0_sel_as", 32'(bus_if.m0_select_as_out), 32'(mon_e.sel_as));
                    chk("resp_m0_data", bus_if.m0_data_out, mon_e.data);
                    chk("resp_m1_none", 32'(bus_if.m1_select_as_out), 32'h0);
                end else begin
                    chk("resp_m1_sel_as", 32'(bus_if.m1_select_as_out), 32'(mon_e.sel_as));
                    chk("resp_m1_data", bus_if.m1_data_out, mon_e.data);
                    chk("resp_m0_none", 32'(bus_if.m0_select_as_out), 32'h0);
                end
            end
        end
    end

    // One bus cycle: drive after the rising edge, check hold and s_sel mid-cycle.
    task automatic step(input logic m0r, input logic m1r, input logic rdy, input logic [31:0] sd,
                        input logic exp_hold, input logic [3:0] exp_sel, input string tag);
        @(posedge clk);
        #1;
        bus_if.m0_req_in  = m0r;
        bus_if.m1_req_in  = m1r;
        bus_if.s_ready_in = rdy;
        bus_if.s_data_in  = sd;
        @(negedge clk);
        chk({tag, "_hold"}, 32'(bus_if.hold_flag_out), 32'(exp_hold));
        chk({tag, "_ssel"}, 32'(bus_if.s_sel_out), 32'(exp_sel));
    endtask

    initial begin
        rst = 1'b1;
        bus_if.m0_req_in  = 1'b0;
        bus_if.m0_addr_in = 32'h0;
        bus_if.m0_data_in = 32'h0;
        bus_if.m0_rw_in   = 1'b0;
        bus_if.m1_req_in  = 1'b0;
        bus_if.m1_addr_in = 32'h0;
        bus_if.m1_data_in = 32'h0;
        bus_if.m1_rw_in   = 1'b0;
        bus_if.s_data_in  = 32'h0;
        bus_if.s_ready_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ssel", 32'(bus_if.s_sel_out), 32'h0);
        chk("rst_saddr", bus_if.s_addr_out, 32'h0);
        chk("rst_hold", 32'(bus_if.hold_flag_out), 32'h0);
        chk("rst_m0_sel_as", 32'(bus_if.m0_select_as_out), 32'h0);
        chk("rst_m1_sel_as", 32'(bus_if.m1_select_as_out), 32'h0);
        chk("rst_m0_data", bus_if.m0_data_out, 32'h0);
        rst = 1'b0;

        // 1: M0 read slave 1, ready after two WAIT cycles; ready in ADDR ignored.
        bus_if.m0_addr_in = 32'h1000_0010;
        bus_if.m0_rw_in   = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, "t1_c0");
        t0 = cyc;
        expect_resp(0, 2'b01, 32'h1234_5678, t0 + 5);
        step(1'b1, 1'b0, 1'b1, 32'hBAD0_0001, 1'b1, 4'b0010, "t1_c1");
        chk("t1_saddr", bus_if.s_addr_out, 32'h1000_0010);
        chk("t1_srw", 32'(bus_if.s_rw_out), 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0010, "t1_c2");
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0010, "t1_c3");
        step(1'b1, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 4'b0010, "t1_c4");
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t1_c5");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t1_c6");

        // 2: simultaneous requests, M0 write first, then M1 read.
        bus_if.m0_addr_in = 32'h0000_0004;
        bus_if.m0_data_in = 32'hA5A5_0001;
        bus_if.m0_rw_in   = 1'b1;
        bus_if.m1_addr_in = 32'h2000_0000;
        bus_if.m1_rw_in   = 1'b0;
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 4'b0000, "t2_c0");
        t0 = cyc;
        expect_resp(0, 2'b10, 32'h0000_0000, t0 + 3);
        expect_resp(1, 2'b01, 32'hCAFE_F00D, t0 + 7);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 4'b0001, "t2_c1");
        chk("t2_saddr_m0", bus_if.s_addr_out, 32'h0000_0004);
        chk("t2_sdata_m0", bus_if.s_data_out, 32'hA5A5_0001);
        chk("t2_srw_m0", 32'(bus_if.s_rw_out), 32'h1);
        step(1'b1, 1'b1, 1'b1, 32'h5555_5555, 1'b1, 4'b0001, "t2_c2");
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0000, "t2_c3");
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0000, "t2_c4");
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0100, "t2_c5");
        chk("t2_saddr_m1", bus_if.s_addr_out, 32'h2000_0000);
        chk("t2_srw_m1", 32'(bus_if.s_rw_out), 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 4'b0100, "t2_c6");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t2_c7");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t2_c8");

        // 3: decode error, straight from ADDR to RESP with zero data.
        bus_if.m0_addr_in = 32'hF000_0000;
        bus_if.m0_rw_in   = 1'b0;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, "t3_c0");
        t0 = cyc;
        expect_resp(0, 2'b01, 32'h0000_0000, t0 + 2);
        step(1'b1, 1'b0, 1'b1, 32'h7777_7777, 1'b1, 4'b0000, "t3_c1");
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t3_c2");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t3_c3");

        // 4: reset while in WAIT aborts with no response afterwards.
        bus_if.m0_addr_in = 32'h3000_0000;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, "t4_c0");
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b1000, "t4_c1");
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b1000, "t4_c2");
        #1;
        rst = 1'b1;
        bus_if.m0_req_in = 1'b0;
        #1;
        chk("t4_async_ssel", 32'(bus_if.s_sel_out), 32'h0);
        chk("t4_async_saddr", bus_if.s_addr_out, 32'h0);
        chk("t4_async_hold", 32'(bus_if.hold_flag_out), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h4444_4444, 1'b0, 4'b0000, "t4_post");
        end

        // 5: slave never ready.
        bus_if.m0_addr_in = 32'h1000_0000;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, "t5_c0");
        t0 = cyc;
`ifdef BUS_TIMEOUT_EN
        expect_resp(0, 2'b01, 32'hDEAD_BEEF, t0 + 18);
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0010, "t5_wait");
        end
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t5_resp");
`else
        expect_resp(0, 2'b01, 32'h0BAD_CAFE, t0 + 103);
        for (int i = 1; i <= 101; i++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0010, "t5_wait");
        end
        step(1'b1, 1'b0, 1'b1, 32'h0BAD_CAFE, 1'b1, 4'b0010, "t5_rdy");
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t5_resp");
`endif
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t5_idle");

        // 6: M0 drops its request during WAIT; the access still completes.
        bus_if.m0_addr_in = 32'h0000_0008;
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0000, "t6_c0");
        t0 = cyc;
        expect_resp(0, 2'b01, 32'h6666_0006, t0 + 4);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 4'b0001, "t6_c1");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0001, "t6_c2");
        step(1'b0, 1'b0, 1'b1, 32'h6666_0006, 1'b0, 4'b0001, "t6_c3");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t6_c4");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t6_c5");

        // 7: M1 keeps requesting after RESP -> second, back-to-back access.
        bus_if.m1_addr_in = 32'h2000_0040;
        bus_if.m1_rw_in   = 1'b0;
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0000, "t7_c0");
        t0 = cyc;
        expect_resp(1, 2'b01, 32'h1111_0001, t0 + 3);
        expect_resp(1, 2'b01, 32'h2222_0002, t0 + 7);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0100, "t7_c1");
        step(1'b0, 1'b1, 1'b1, 32'h1111_0001, 1'b0, 4'b0100, "t7_c2");
        bus_if.m1_addr_in = 32'h2000_0100;
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0000, "t7_c3");
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0000, "t7_c4");
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 4'b0100, "t7_c5");
        chk("t7_saddr2", bus_if.s_addr_out, 32'h2000_0100);
        step(1'b0, 1'b1, 1'b1, 32'h2222_0002, 1'b0, 4'b0100, "t7_c6");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t7_c7");
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 4'b0000, "t7_c8");

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
